// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register file write-port arbiter with result FIFO, busy scoreboard and starvation guard
module rf_wb_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p_we,
  input  logic [4:0]  p_wa,
  input  logic [31:0] p_wd,
  input  logic        m_valid,
  output logic        m_ready,
  input  logic [4:0]  m_wa,
  input  logic [31:0] m_wd,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic        hz1,
  output logic        hz2,
  output logic        stall_pipe,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd
);

  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CLW = $clog2(STARVE_LIMIT + 1);
  localparam int CW  = (CLW < 3) ? 3 : CLW;

  typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n, cnt_inc;
  logic [4:0]     mem_wa [FIFO_DEPTH];
  logic [31:0]    mem_wd [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count, count_n;
  logic [31:0]    busy, set_vec, clr_vec;
  logic [4:0]     head_wa;
  logic [31:0]    head_wd;
  logic           p_req, empty, full, push, pop, head_denied;

  assign p_req       = p_we && (p_wa != 5'd0);
  assign empty       = (count == '0);
  assign full        = (count == (AW+1)'(FIFO_DEPTH));
  assign m_ready     = !full;
  assign push        = m_valid && !full;
  // A forced slot always goes to the head; otherwise the head only takes idle slots.
  assign pop         = !empty && ((state == FORCE) || !p_req);
  assign head_denied = !empty && !pop;
  assign head_wa     = mem_wa[rd_ptr];
  assign head_wd     = mem_wd[rd_ptr];
  assign count_n     = count + (AW+1)'(push) - (AW+1)'(pop);
  assign cnt_inc     = cnt + CW'(1);

  // Result storage; contents are don't-care once the pointers reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_wa[wr_ptr] <= m_wa;
      mem_wd[wr_ptr] <= m_wd;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_n;
    end
  end

  // Write-port mux: x0 drains consume the slot but do not write.
  always_comb begin
    rf_we = 1'b0;
    rf_wa = 5'd0;
    rf_wd = 32'd0;
    if (!rst_n) begin
      rf_we = 1'b0;
    end else if (pop) begin
      rf_we = (head_wa != 5'd0);
      rf_wa = head_wa;
      rf_wd = head_wd;
    end else if (p_req && (state != FORCE)) begin
      rf_we = 1'b1;
      rf_wa = p_wa;
      rf_wd = p_wd;
    end
  end

  // Busy scoreboard: an issue to the register being drained keeps it busy.
  always_comb begin
    set_vec = 32'd0;
    clr_vec = 32'd0;
    if (iss_valid && (iss_rd != 5'd0)) set_vec = 32'd1 << iss_rd;
    if (pop)                           clr_vec = 32'd1 << head_wa;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= 32'd0;
    else        busy <= (busy & ~clr_vec) | set_vec;
  end

  // Hazards see the same-cycle drain because the register file writes on the falling edge.
  assign hz1 = (ra1 != 5'd0) && busy[ra1] && !(pop && (head_wa == ra1));
  assign hz2 = (ra2 != 5'd0) && busy[ra2] && !(pop && (head_wa == ra2));

  // Starvation next-state: count consecutive denials of the head, force a slot at the limit.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (head_denied) begin
          cnt_n   = CW'(1);
          state_n = (STARVE_LIMIT <= 1) ? FORCE : WAIT;
        end
      end
      WAIT: begin
        if (empty) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else if (head_denied) begin
          cnt_n = cnt_inc;
          if (cnt_inc >= CW'(STARVE_LIMIT)) state_n = FORCE;
        end else begin
          cnt_n   = '0;
          state_n = (count_n == '0) ? IDLE : WAIT;
        end
      end
      FORCE: begin
        cnt_n   = '0;
        state_n = (count_n == '0) ? IDLE : WAIT;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // Starvation state register; stall_pipe is registered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      stall_pipe <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      stall_pipe <= (state_n == FORCE);
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - directed self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p_we;
  logic [4:0]  p_wa;
  logic [31:0] p_wd;
  logic        m_valid;
  logic        m_ready;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic        hz1;
  logic        hz2;
  logic        stall_pipe;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  int n_checks = 0;
  int n_fail   = 0;

  rf_wb_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .p_we(p_we), .p_wa(p_wa), .p_wd(p_wd),
    .m_valid(m_valid), .m_ready(m_ready), .m_wa(m_wa), .m_wd(m_wd),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .ra1(ra1), .ra2(ra2), .hz1(hz1), .hz2(hz2),
    .stall_pipe(stall_pipe),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge, then settle new inputs before sampling.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; p_we = 1'b1; p_wa = 5'd4; p_wd = 32'h44;
    m_valid = 1'b0; m_wa = 5'd0; m_wd = 32'd0;
    iss_valid = 1'b0; iss_rd = 5'd0; ra1 = 5'd0; ra2 = 5'd0;
    #2;
    check("rst_rf_we", 32'(rf_we), 0);
    check("rst_m_ready", 32'(m_ready), 1);
    check("rst_stall", 32'(stall_pipe), 0);
    p_we = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;

    // Uncontended drain
    cyc();
    iss_valid = 1'b1; iss_rd = 5'd5; ra1 = 5'd5; #1;
    check("ud_c0_hz1", 32'(hz1), 0);
    cyc(); iss_valid = 1'b0; #1;
    check("ud_c1_hz1", 32'(hz1), 1);
    cyc(); #1;
    check("ud_c2_hz1", 32'(hz1), 1);
    cyc(); m_valid = 1'b1; m_wa = 5'd5; m_wd = 32'hDEADBEEF; #1;
    check("ud_c3_hz1", 32'(hz1), 1);
    check("ud_c3_rf_we", 32'(rf_we), 0);
    cyc(); m_valid = 1'b0; #1;
    check("ud_c4_rf_we", 32'(rf_we), 1);
    check("ud_c4_rf_wa", 32'(rf_wa), 5);
    check("ud_c4_rf_wd", rf_wd, 32'hDEADBEEF);
    check("ud_c4_hz1", 32'(hz1), 0);
    cyc(); #1;
    check("ud_c5_hz1", 32'(hz1), 0);
    check("ud_c5_rf_we", 32'(rf_we), 0);

    // Priority: pipeline beats the FIFO, x7 drains on the first idle slot
    cyc(); m_valid = 1'b1; m_wa = 5'd7; m_wd = 32'h77; #1;
    cyc(); m_valid = 1'b0; p_we = 1'b1; p_wa = 5'd3; p_wd = 32'h33; #1;
    check("pr_rf_wa", 32'(rf_wa), 3);
    check("pr_rf_wd", rf_wd, 32'h33);
    cyc(); p_we = 1'b0; #1;
    check("pr_drain_we", 32'(rf_we), 1);
    check("pr_drain_wa", 32'(rf_wa), 7);
    check("pr_drain_wd", rf_wd, 32'h77);

    // Starvation: four denied cycles, then one forced slot
    cyc(); m_valid = 1'b1; m_wa = 5'd11; m_wd = 32'hB0B0; #1;
    cyc(); m_valid = 1'b0; p_we = 1'b1; p_wa = 5'd2; p_wd = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("sv_denied_wa", 32'(rf_wa), 2);
      check("sv_denied_stall", 32'(stall_pipe), 0);
      cyc();
    end
    #1;
    check("sv_force_stall", 32'(stall_pipe), 1);
    check("sv_force_we", 32'(rf_we), 1);
    check("sv_force_wa", 32'(rf_wa), 11);
    check("sv_force_wd", rf_wd, 32'hB0B0);
    cyc(); #1;
    check("sv_after_stall", 32'(stall_pipe), 0);
    check("sv_after_wa", 32'(rf_wa), 2);
    cyc(); p_we = 1'b0; #1;
    check("sv_empty_we", 32'(rf_we), 0);
    check("sv_empty_stall", 32'(stall_pipe), 0);

    // Full FIFO with the pipeline writing every cycle
    cyc(); p_we = 1'b1; p_wa = 5'd1; p_wd = 32'h11;
    m_valid = 1'b1; m_wa = 5'd12; m_wd = 32'hC0; #1;
    check("ff_f0_ready", 32'(m_ready), 1);
    cyc(); m_wa = 5'd13; m_wd = 32'hC1; #1;
    check("ff_f1_ready", 32'(m_ready), 1);
    cyc(); m_wa = 5'd14; m_wd = 32'hC2; #1;
    check("ff_f2_ready", 32'(m_ready), 0);
    check("ff_f2_wa", 32'(rf_wa), 1);
    cyc(); #1;
    check("ff_f3_ready", 32'(m_ready), 0);
    cyc(); #1;
    check("ff_f4_stall", 32'(stall_pipe), 0);
    cyc(); #1;
    check("ff_f5_stall", 32'(stall_pipe), 1);
    check("ff_f5_wa", 32'(rf_wa), 12);
    check("ff_f5_ready", 32'(m_ready), 0);
    cyc(); #1;
    check("ff_f6_ready", 32'(m_ready), 1);
    check("ff_f6_wa", 32'(rf_wa), 1);
    cyc(); m_valid = 1'b0; p_we = 1'b0; #1;
    check("ff_f7_ready", 32'(m_ready), 0);
    check("ff_f7_wa", 32'(rf_wa), 13);
    check("ff_f7_wd", rf_wd, 32'hC1);
    cyc(); #1;
    check("ff_f8_wa", 32'(rf_wa), 14);
    check("ff_f8_wd", rf_wd, 32'hC2);
    check("ff_f8_ready", 32'(m_ready), 1);
    cyc(); #1;
    check("ff_f9_we", 32'(rf_we), 0);

    // Pipeline request to x0 leaves the slot to the FIFO
    cyc(); m_valid = 1'b1; m_wa = 5'd15; m_wd = 32'hF5; #1;
    cyc(); m_valid = 1'b0; p_we = 1'b1; p_wa = 5'd0; p_wd = 32'h99; #1;
    check("x0_p_we", 32'(rf_we), 1);
    check("x0_p_wa", 32'(rf_wa), 15);
    // FIFO entry to x0 drains without writing
    cyc(); p_we = 1'b0; m_valid = 1'b1; m_wa = 5'd0; m_wd = 32'h5A; #1;
    cyc(); m_valid = 1'b0; #1;
    check("x0_m_we", 32'(rf_we), 0);
    cyc(); p_we = 1'b1; p_wa = 5'd6; p_wd = 32'h66; #1;
    check("x0_m_gone_wa", 32'(rf_wa), 6);
    p_we = 1'b0;

    // Collision: issue to x9 in the cycle x9 drains keeps it busy
    cyc(); iss_valid = 1'b1; iss_rd = 5'd9; ra1 = 5'd9; ra2 = 5'd9; #1;
    cyc(); iss_valid = 1'b0; m_valid = 1'b1; m_wa = 5'd9; m_wd = 32'h9; #1;
    check("co_busy_hz2", 32'(hz2), 1);
    cyc(); m_valid = 1'b0; iss_valid = 1'b1; iss_rd = 5'd9; #1;
    check("co_drain_wa", 32'(rf_wa), 9);
    check("co_drain_hz1", 32'(hz1), 0);
    cyc(); iss_valid = 1'b0; #1;
    check("co_after_hz1", 32'(hz1), 1);
    check("co_after_hz2", 32'(hz2), 1);
    ra2 = 5'd0; #1;
    check("co_ra0_hz2", 32'(hz2), 0);

    // Reset mid-operation: two entries, busy set, state WAIT
    cyc(); iss_valid = 1'b1; iss_rd = 5'd20; ra1 = 5'd20; ra2 = 5'd20;
    p_we = 1'b1; p_wa = 5'd1; m_valid = 1'b1; m_wa = 5'd21; m_wd = 32'h21; #1;
    cyc(); iss_valid = 1'b0; m_wa = 5'd22; m_wd = 32'h22; #1;
    cyc(); m_valid = 1'b0; #1;
    check("rm_pre_ready", 32'(m_ready), 0);
    check("rm_pre_hz1", 32'(hz1), 1);
    rst_n = 1'b0; #1;
    check("rm_rf_we", 32'(rf_we), 0);
    check("rm_stall", 32'(stall_pipe), 0);
    check("rm_ready", 32'(m_ready), 1);
    check("rm_hz1", 32'(hz1), 0);
    check("rm_hz2", 32'(hz2), 0);
    cyc();
    rst_n = 1'b1; p_we = 1'b0; #1;
    check("rm_post_we", 32'(rf_we), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
